// File: rtl/seg7_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display-code side and the pin side of the multiplexed
// 7-segment driver.
//   value      : 5*DIGITS digit codes, digit 0 in value[4:0]
//   load       : one-cycle strobe that captures value
//   lzs        : leading-zero suppression enable (level)
//   seg        : segments {a,b,c,d,e,f,g}
//   an         : one-hot digit enable
//   frame_done : one-cycle pulse when the scan wraps to digit 0
// master = producer of display codes / consumer of pins, slave = the driver.
// ----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [5*DIGITS-1:0] value;
  logic                load;
  logic                lzs;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, load, lzs,
    input  seg, an, frame_done
  );

  modport slave (
    input  value, load, lzs,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for DIGITS seven-segment digits sharing one segment
// bus. A prescaler holds each digit lit for CLK_DIV cycles; new display codes
// are double-buffered (pending -> shadow) and only swap in at the frame
// boundary, so a frame never mixes old and new digits.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous, active-low reset
//   bus   : seg7_scan_driver_if slave (value/load/lzs in, seg/an/frame_done out)
// Parameters:
//   DIGITS     : digits scanned (2..8)
//   CLK_DIV    : cycles each digit stays lit (>=2)
//   ACTIVE_LOW : 1 inverts seg and an at the output register
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int   CW  = $clog2(CLK_DIV);
  localparam int   IW  = $clog2(DIGITS);
  localparam int   VW  = 5 * DIGITS;
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              lit_q, lit_d;
  logic [VW-1:0]     pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q;

  logic tick, wrap;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'b1111110;
      5'd1:    decode = 7'b0110000;
      5'd2:    decode = 7'b1101101;
      5'd3:    decode = 7'b1111001;
      5'd4:    decode = 7'b0110011;
      5'd5:    decode = 7'b1011011;
      5'd6:    decode = 7'b1011111;
      5'd7:    decode = 7'b1110000;
      5'd8:    decode = 7'b1111111;
      5'd9:    decode = 7'b1111011;
      5'd10:   decode = 7'b1110111;
      5'd11:   decode = 7'b0011111;
      5'd12:   decode = 7'b1001110;
      5'd13:   decode = 7'b0111101;
      5'd14:   decode = 7'b1001111;
      5'd15:   decode = 7'b1000111;
      5'd16:   decode = 7'b0000001;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // Scan and buffering next-state.
  always_comb begin
    tick = (cnt_q == CW'(CLK_DIV - 1));
    // Frame boundary: a tick that takes the scan from the last digit to 0.
    wrap = tick && lit_q && (idx_q == IW'(DIGITS - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    // The very first tick lights digit 0 rather than advancing past it.
    lit_d = lit_q | tick;
    idx_d = idx_q;
    if (tick && lit_q) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    shadow_d        = shadow_q;
    if (bus.load) begin
      pending_d       = bus.value;
      pending_valid_d = 1'b1;
    end
    if (wrap) begin
      // A load landing on the boundary bypasses pending.
      if (bus.load) begin
        shadow_d        = bus.value;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        shadow_d        = pending_q;
        pending_valid_d = 1'b0;
      end
    end
  end

  // Per-digit codes taken from the next shadow value so a fresh frame
  // displays fresh data from its very first digit.
  logic [4:0] code [DIGITS];
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_code
      assign code[gi] = shadow_d[5*gi +: 5];
    end
  endgenerate

  logic [DIGITS-1:0] lead_zero;
  logic              zero_run;
  logic              blank;

  always_comb begin
    // lead_zero[i] = codes of digits DIGITS-1..i are all zero.
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (code[i] == 5'd0);
      lead_zero[i] = zero_run;
    end
    blank = bus.lzs && (idx_d != '0) && lead_zero[idx_d];

    seg_d = '0;
    an_d  = '0;
    if (lit_d) begin
      seg_d = blank ? 7'b0000000 : decode(code[idx_d]);
      an_d  = DIGITS'(1) << idx_d;
    end
    seg_d = seg_d ^ {7{INV}};
    an_d  = an_d ^ {DIGITS{INV}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      idx_q           <= '0;
      lit_q           <= 1'b0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      shadow_q        <= '0;
      seg_q           <= {7{INV}};
      an_q            <= {DIGITS{INV}};
      frame_done_q    <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      lit_q           <= lit_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      shadow_q        <= shadow_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
      frame_done_q    <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4. Two DUTs run
// in lockstep on identical inputs: one active-high, one active-low.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;
  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();
  seg7_scan_driver_if #(.DIGITS(4)) bus_al ();

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1)) dut_al (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [19:0] v, input logic ld, input logic lz);
    bus.value    = v;
    bus.load     = ld;
    bus.lzs      = lz;
    bus_al.value = v;
    bus_al.load  = ld;
    bus_al.lzs   = lz;
  endtask

  // One-cycle load strobe.
  task automatic do_load(input logic [19:0] v, input logic lz);
    set_in(v, 1'b1, lz);
    step(1);
    bus.load    = 1'b0;
    bus_al.load = 1'b0;
    $display("load value=%h lzs=%0b", v, lz);
  endtask

  // Advance to the sample where frame_done is high (digit 0 of a new frame).
  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (bus.frame_done !== 1'b1 && k < 100);
    n_checks++;
    if (bus.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", bus.frame_done, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus.an !== 4'b0000 || bus.seg !== 7'b0000000 || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_off c%0d: an=%b seg=%b fd=%b required an=0000 seg=0000000 fd=0",
                 c, bus.an, bus.seg, bus.frame_done);
      end
      n_checks++;
      if (bus_al.an !== 4'b1111 || bus_al.seg !== 7'b1111111) begin
        n_fail++;
        $display("FAIL reset_off_al c%0d: an=%b seg=%b required an=1111 seg=1111111",
                 c, bus_al.an, bus_al.seg);
      end
      step(1);
    end
    n_checks++;
    if (bus.an !== 4'b0001 || bus.seg !== 7'b1111110) begin
      n_fail++;
      $display("FAIL first_digit: an=%b seg=%b required an=0001 seg=1111110", bus.an, bus.seg);
    end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    int fd_count;
    for (int i = 1; i < 4; i++) begin
      step(4);
      exp_an = 4'b0001 << i;
      n_checks++;
      if (bus.an !== exp_an || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_walk d%0d: an=%b fd=%b required an=%b fd=0", i, bus.an, bus.frame_done, exp_an);
      end
    end
    step(4);
    n_checks++;
    if (bus.an !== 4'b0001 || bus.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_wrap: an=%b fd=%b required an=0001 fd=1", bus.an, bus.frame_done);
    end
    fd_count = 0;
    for (int c = 0; c < 16; c++) begin
      step(1);
      if (bus.frame_done === 1'b1) fd_count++;
    end
    n_checks++;
    if (fd_count != 1) begin
      n_fail++;
      $display("FAIL frame_done_rate: %0d pulses in 16 cycles, required 1", fd_count);
    end
    $display("test_scan done");
  endtask

  task automatic test_load();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = 7'b1111110;
    exp_seg[1] = 7'b0110000;
    exp_seg[2] = 7'b1101101;
    exp_seg[3] = 7'b1111001;
    wait_frame();
    step(2);
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 1'b0);
    step(1);
    n_checks++;
    if (bus.an !== 4'b0010 || bus.seg !== 7'b1111110) begin
      n_fail++;
      $display("FAIL load_old_frame: an=%b seg=%b required an=0010 seg=1111110", bus.an, bus.seg);
    end
    wait_frame();
    for (int i = 0; i < 4; i++) begin
      exp_an = 4'b0001 << i;
      n_checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg[i]) begin
        n_fail++;
        $display("FAIL load_new d%0d: an=%b seg=%b required an=%b seg=%b", i, bus.an, bus.seg, exp_an, exp_seg[i]);
      end
      if (i < 3) step(4);
    end
    $display("test_load done");
  endtask

  task automatic test_last_wins();
    wait_frame();
    step(1);
    do_load({4{5'd5}}, 1'b0);
    do_load({4{5'd10}}, 1'b0);
    n_checks++;
    if (bus.an !== 4'b0001 || bus.seg !== 7'b1111110) begin
      n_fail++;
      $display("FAIL last_wins_old: an=%b seg=%b required an=0001 seg=1111110", bus.an, bus.seg);
    end
    wait_frame();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.seg !== 7'b1110111) begin
        n_fail++;
        $display("FAIL last_wins d%0d: seg=%b required 1110111", i, bus.seg);
      end
      if (i < 3) step(4);
    end
    $display("test_last_wins done");
  endtask

  task automatic test_lzs();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = 7'b1111110;
    exp_seg[1] = 7'b0000001;
    exp_seg[2] = 7'b0000000;
    exp_seg[3] = 7'b0000000;
    do_load({5'd0, 5'd0, 5'd16, 5'd0}, 1'b1);
    wait_frame();
    for (int i = 0; i < 4; i++) begin
      exp_an = 4'b0001 << i;
      n_checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg[i]) begin
        n_fail++;
        $display("FAIL lzs_dash d%0d: an=%b seg=%b required an=%b seg=%b", i, bus.an, bus.seg, exp_an, exp_seg[i]);
      end
      if (i < 3) step(4);
    end
    do_load(20'd0, 1'b1);
    wait_frame();
    for (int i = 0; i < 4; i++) begin
      exp_an = 4'b0001 << i;
      n_checks++;
      if (bus.an !== exp_an || bus.seg !== ((i == 0) ? 7'b1111110 : 7'b0000000)) begin
        n_fail++;
        $display("FAIL lzs_zero d%0d: an=%b seg=%b required an=%b seg=%b", i, bus.an, bus.seg, exp_an,
                 (i == 0) ? 7'b1111110 : 7'b0000000);
      end
      if (i < 3) step(4);
    end
    // Still on digit 3: dropping lzs shows the zero on the next cycle.
    set_in(20'd0, 1'b0, 1'b0);
    step(1);
    n_checks++;
    if (bus.an !== 4'b1000 || bus.seg !== 7'b1111110) begin
      n_fail++;
      $display("FAIL lzs_off: an=%b seg=%b required an=1000 seg=1111110", bus.an, bus.seg);
    end
    $display("test_lzs done");
  endtask

  task automatic test_boundary_load();
    wait_frame();
    step(15);
    set_in({4{5'd7}}, 1'b1, 1'b0);
    step(1);
    set_in({4{5'd7}}, 1'b0, 1'b0);
    $display("load value=%h on boundary", {4{5'd7}});
    n_checks++;
    if (bus.frame_done !== 1'b1 || bus.an !== 4'b0001 || bus.seg !== 7'b1110000) begin
      n_fail++;
      $display("FAIL boundary_load: fd=%b an=%b seg=%b required fd=1 an=0001 seg=1110000",
               bus.frame_done, bus.an, bus.seg);
    end
    $display("test_boundary_load done");
  endtask

  task automatic test_active_low();
    do_load({5'd0, 5'd0, 5'd0, 5'd8}, 1'b0);
    wait_frame();
    n_checks++;
    if (bus_al.seg !== 7'b0000000 || bus_al.an !== 4'b1110) begin
      n_fail++;
      $display("FAIL al_d0: seg=%b an=%b required seg=0000000 an=1110", bus_al.seg, bus_al.an);
    end
    n_checks++;
    if (bus.seg !== 7'b1111111 || bus.an !== 4'b0001) begin
      n_fail++;
      $display("FAIL ah_d0: seg=%b an=%b required seg=1111111 an=0001", bus.seg, bus.an);
    end
    step(4);
    n_checks++;
    if (bus_al.seg !== 7'b0000001 || bus_al.an !== 4'b1101) begin
      n_fail++;
      $display("FAIL al_d1: seg=%b an=%b required seg=0000001 an=1101", bus_al.seg, bus_al.an);
    end
    $display("test_active_low done");
  endtask

  task automatic test_reset_mid();
    wait_frame();
    step(8);
    n_checks++;
    if (bus.an !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_pre: an=%b required 0100", bus.an);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.an !== 4'b0000 || bus.seg !== 7'b0000000 || bus.frame_done !== 1'b0
        || bus_al.an !== 4'b1111 || bus_al.seg !== 7'b1111111) begin
      n_fail++;
      $display("FAIL mid_async: an=%b seg=%b al_an=%b al_seg=%b required 0000 0000000 1111 1111111",
               bus.an, bus.seg, bus_al.an, bus_al.seg);
    end
    step(2);
    rst_n = 1'b1;
    step(3);
    n_checks++;
    if (bus.an !== 4'b0000 || bus.seg !== 7'b0000000) begin
      n_fail++;
      $display("FAIL mid_still_off: an=%b seg=%b required an=0000 seg=0000000", bus.an, bus.seg);
    end
    step(1);
    // Shadow held code 8 on digit 0 before reset; a cleared shadow shows 0.
    n_checks++;
    if (bus.an !== 4'b0001 || bus.seg !== 7'b1111110) begin
      n_fail++;
      $display("FAIL mid_restart: an=%b seg=%b required an=0001 seg=1111110", bus.an, bus.seg);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_in(20'd0, 1'b0, 1'b0);
    step(3);
    test_reset();
    test_scan();
    test_load();
    test_last_wins();
    test_lzs();
    test_boundary_load();
    test_active_low();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
